// File: rtl/johnson_phase_decoder_if.sv
// Bus between the upstream 4-bit Johnson counter and johnson_phase_decoder.
// Master drives the count q; slave returns the registered decode and status.
interface johnson_phase_decoder_if;
    logic [3:0] q;
    logic [7:0] phase;
    logic [2:0] step;
    logic       illegal;
    logic       locked;
    logic       wrap;
    logic [7:0] rev_cnt;
    logic [7:0] err_cnt;

    modport master (
        output q,
        input  phase, step, illegal, locked, wrap, rev_cnt, err_cnt
    );

    modport slave (
        input  q,
        output phase, step, illegal, locked, wrap, rev_cnt, err_cnt
    );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Decodes a 4-bit Johnson count into a step/one-hot phase, tracks lock, revolutions and errors.
// Optional macro JDEC_HOLD_ALLOW_EN: a legal code held for a cycle counts as a stall, not an error.
module johnson_phase_decoder (
    input  logic                     CLK,
    input  logic                     CLR,
    johnson_phase_decoder_if.slave   jif
);
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned PHASE_W = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned RUN_W   = 2;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    // Returns {legal, step} for a Johnson code.
    function automatic logic [STEP_W:0] decode(input logic [CODE_W-1:0] code);
        logic [STEP_W:0] r;
        case (code)
            4'b0000: r = {1'b1, 3'd0};
            4'b0001: r = {1'b1, 3'd1};
            4'b0011: r = {1'b1, 3'd2};
            4'b0111: r = {1'b1, 3'd3};
            4'b1111: r = {1'b1, 3'd4};
            4'b1110: r = {1'b1, 3'd5};
            4'b1100: r = {1'b1, 3'd6};
            4'b1000: r = {1'b1, 3'd7};
            default: r = {1'b0, 3'd0};
        endcase
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [RUN_W-1:0]    good_run_q, good_run_d;
    logic [CODE_W-1:0]   prev_q_q;
    logic                prev_valid_q;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                illegal_q, illegal_d;
    logic                locked_q, locked_d;
    logic                wrap_q, wrap_d;
    logic [CNT_W-1:0]    rev_cnt_q, rev_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic [STEP_W:0]     cur_dec_c, prv_dec_c;
    logic                cur_legal_c, prv_legal_c;
    logic [STEP_W-1:0]   cur_step_c, prv_step_c;
    logic                trans_ok_c, hold_ok_c, bad_c, wrap_evt_c;

    // Classify the current sample against the previous one.
    always_comb begin
        cur_dec_c   = decode(jif.q);
        prv_dec_c   = decode(prev_q_q);
        cur_legal_c = cur_dec_c[STEP_W];
        cur_step_c  = cur_dec_c[STEP_W-1:0];
        prv_legal_c = prv_dec_c[STEP_W];
        prv_step_c  = prv_dec_c[STEP_W-1:0];
        trans_ok_c  = prev_valid_q && prv_legal_c && cur_legal_c &&
                      (STEP_W'(prv_step_c + 3'd1) == cur_step_c);
`ifdef JDEC_HOLD_ALLOW_EN
        hold_ok_c   = prev_valid_q && prv_legal_c && cur_legal_c && (prv_step_c == cur_step_c);
`else
        hold_ok_c   = 1'b0;
`endif
        // First sample after reset is judged on code legality alone.
        bad_c       = !cur_legal_c || (prev_valid_q && !trans_ok_c && !hold_ok_c);
        wrap_evt_c  = trans_ok_c && (prv_step_c == 3'd7) && (cur_step_c == 3'd0);
    end

    // Lock FSM next-state plus counter and output updates.
    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        rev_cnt_d  = rev_cnt_q;
        err_cnt_d  = err_cnt_q;
        wrap_d     = 1'b0;

        case (state_q)
            ST_UNLOCKED: begin
                if (bad_c) begin
                    good_run_d = '0;
                end else if (trans_ok_c) begin
                    if (good_run_q == 2'd3) begin
                        state_d    = ST_LOCKED;
                        good_run_d = '0;
                    end else begin
                        good_run_d = RUN_W'(good_run_q + 2'd1);
                    end
                end
            end
            ST_LOCKED: begin
                if (bad_c) begin
                    state_d = ST_ERROR;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = CNT_W'(err_cnt_q + 8'd1);
                    end
                end else if (wrap_evt_c) begin
                    wrap_d    = 1'b1;
                    rev_cnt_d = CNT_W'(rev_cnt_q + 8'd1);
                end
            end
            ST_ERROR: begin
                state_d    = ST_UNLOCKED;
                good_run_d = '0;
            end
            default: begin
                state_d    = ST_UNLOCKED;
                good_run_d = '0;
            end
        endcase

        phase_d   = cur_legal_c ? (PHASE_W'(1) << cur_step_c) : '0;
        step_d    = cur_legal_c ? cur_step_c : step_q;
        illegal_d = bad_c;
        locked_d  = (state_d == ST_LOCKED);
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q      <= ST_UNLOCKED;
            good_run_q   <= '0;
            prev_q_q     <= '0;
            prev_valid_q <= 1'b0;
            phase_q      <= '0;
            step_q       <= '0;
            illegal_q    <= 1'b0;
            locked_q     <= 1'b0;
            wrap_q       <= 1'b0;
            rev_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            good_run_q   <= good_run_d;
            prev_q_q     <= jif.q;
            prev_valid_q <= 1'b1;
            phase_q      <= phase_d;
            step_q       <= step_d;
            illegal_q    <= illegal_d;
            locked_q     <= locked_d;
            wrap_q       <= wrap_d;
            rev_cnt_q    <= rev_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign jif.phase   = phase_q;
    assign jif.step    = step_q;
    assign jif.illegal = illegal_q;
    assign jif.locked  = locked_q;
    assign jif.wrap    = wrap_q;
    assign jif.rev_cnt = rev_cnt_q;
    assign jif.err_cnt = err_cnt_q;

endmodule

// File: doc/johnson_phase_decoder.md
JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single rising-edge clock shared with the upstream 4-bit Johnson counter.
REQ-002 SHALL have port CLR, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port q, input, 4 bits: Johnson count from the upstream counter.
REQ-004 SHALL have port phase, output, 8 bits: registered one-hot decode of the step, all-zero when no legal step is present.
REQ-005 SHALL have port step, output, 3 bits: registered binary step index 0..7.
REQ-006 SHALL have port illegal, output, 1 bit: registered pulse for an illegal code or an illegal transition.
REQ-007 SHALL have port locked, output, 1 bit: high while the state machine is in LOCKED.
REQ-008 SHALL have port wrap, output, 1 bit: one-cycle pulse on each completed revolution.
REQ-009 SHALL have port rev_cnt, output, 8 bits: revolution counter that wraps modulo 256.
REQ-010 SHALL have port err_cnt, output, 8 bits: error counter that saturates at 255.

Function
REQ-011 SHALL map legal codes to step values: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7; the other 8 codes are illegal.
REQ-012 SHALL sample q at every CLK rise into prev_q, with a prev_valid flag.
REQ-013 SHALL register all outputs, giving 1-cycle latency: the outputs after edge N reflect the q sampled at edge N.
REQ-014 SHALL define a legal transition as step(prev_q)+1 mod 8 equal to step(q), with both codes legal.
REQ-015 SHALL evaluate no transition check on the first sample after reset (prev_valid=0); that sample is judged on code legality only.
REQ-016 SHALL set phase[step]=1 and update step for a legal code; for an illegal code it SHALL set phase=0, hold step and pulse illegal.
REQ-017 SHALL pulse illegal for 1 cycle on an illegal transition, even when both codes are legal.
REQ-018 SHALL implement the FSM states UNLOCKED, LOCKED and ERROR, with an internal 2-bit good-run counter.
REQ-019 In UNLOCKED, each legal transition SHALL increment good-run and any illegal event SHALL clear it; the 4th consecutive legal transition SHALL move the FSM to LOCKED on that edge.
REQ-020 In LOCKED, any illegal event SHALL move the FSM to ERROR and increment err_cnt, saturating at 255.
REQ-021 ERROR SHALL last exactly 1 cycle and then go to UNLOCKED with good-run=0, whatever q is.
REQ-022 SHALL pulse wrap and increment rev_cnt on a LOCKED-state legal transition 7->0; 255 SHALL wrap to 0.
REQ-023 Illegal events in UNLOCKED or ERROR SHALL pulse illegal but SHALL NOT change err_cnt.
REQ-024 SHALL NOT pulse wrap when the illegal event and a 7->0 transition occur on the same edge (the illegal event wins).

Reset
REQ-025 SHALL, when CLR=0, immediately and without waiting for CLK set: phase=0, step=0, illegal=0, locked=0, wrap=0, rev_cnt=0, err_cnt=0, FSM=UNLOCKED, good-run=0, prev_valid=0, prev_q=0000.
REQ-026 SHALL take effect mid-revolution or mid-ERROR with no residual pulses; the first CLK edge after CLR deasserts is treated as the first sample.

Configuration
REQ-027 SHALL use the macro JDEC_HOLD_ALLOW_EN; when it is defined, step(q)==step(prev_q) with a legal code SHALL count as legal (a stalled counter): good-run unchanged, no wrap, no illegal.
REQ-028 When JDEC_HOLD_ALLOW_EN is undefined, a held code SHALL count as an illegal transition.

Verification
REQ-029 After reset release, drive a clean Johnson sequence starting at 0000 -> locked=1 after the 5th edge, phase follows 0x01,0x02,0x04 and so on, err_cnt=0.
REQ-030 While locked, run 3 full revolutions -> wrap pulses 3 times, one each on the 7->0 edge, and rev_cnt=3.
REQ-031 While locked, inject q=0101 for 1 cycle -> phase=0, illegal=1, FSM goes to ERROR then UNLOCKED, err_cnt=1, locked=0 until 4 further legal transitions.
REQ-032 While locked, skip a step (0011 followed by 1111) -> illegal=1, err_cnt increments, step=4, phase=0x10.
REQ-033 Hold q=0111 for 2 cycles while locked -> with JDEC_HOLD_ALLOW_EN, locked stays 1; without it, illegal=1 and err_cnt increments.
REQ-034 Assert CLR between clock edges mid-revolution with err_cnt=255 -> all outputs zero immediately; after release, 300 errors leave err_cnt at 255 (saturation).
